// File: rtl/gps_ser_if.sv
// gps_ser_if: request, GPS-side serial strobes and word handshake of gps_ser_reader
//   start/sel/nbits : transfer request (master -> slave)
//   op/rdReg/rdBit  : strobes to the GPS block; ser : serial data from it
//   word/word_valid/word_last/word_ready : output word handshake
//   busy/done       : transfer status
interface gps_ser_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [2:0]        sel;
    logic [CNT_W-1:0]  nbits;
    logic [15:0]       op;
    logic              rdReg;
    logic              rdBit;
    logic              ser;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    logic              busy;
    logic              done;
    modport master (
        output start, sel, nbits, ser, word_ready,
        input  op, rdReg, rdBit, word, word_valid, word_last, busy, done
    );
    modport slave (
        input  start, sel, nbits, ser, word_ready,
        output op, rdReg, rdBit, word, word_valid, word_last, busy, done
    );
endinterface

// File: rtl/gps_ser_reader.sv
// gps_ser_reader: reads nbits serial bits from the GPS block and packs them MSB-first into WORD_W words
//   clk, rst : clock, synchronous active-high reset
//   bus      : gps_ser_if slave (request, GPS strobes/serial data, word handshake, busy/done)
module gps_ser_reader #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input logic      clk,
    input logic      rst,
    gps_ser_if.slave bus
);
    localparam int AW = $clog2(WORD_W);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} state_t;
    state_t            state, state_n;
    logic [2:0]        sel_q;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] acc, acc_n, word_q;
    logic [AW-1:0]     nacc;
    logic              valid_q, last_q;
    logic              accept, last_bit, fin, take;
    assign accept   = valid_q && bus.word_ready;
    assign last_bit = cnt == CNT_W'(1);
    // the bit sampled now closes a word (full or final partial)
    assign fin      = last_bit || nacc == AW'(WORD_W - 1);
    assign acc_n    = {acc[WORD_W-2:0], bus.ser};
    always_comb begin
        state_n = state;
        take    = 1'b0;
        case (state)
            IDLE:  state_n = (bus.start && bus.nbits != '0) ? LOAD : IDLE;
            LOAD:  state_n = SHIFT;
            SHIFT: begin
                // a word-closing bit is only taken when the output register can receive it
                take    = !fin || !valid_q || bus.word_ready;
                state_n = (take && last_bit) ? DRAIN : SHIFT;
            end
            DRAIN: state_n = accept ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            cnt     <= '0;
            acc     <= '0;
            nacc    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == LOAD) begin
                sel_q <= bus.sel;
                cnt   <= bus.nbits;
                acc   <= '0;
                nacc  <= '0;
            end
            if (take) begin
                cnt  <= cnt - CNT_W'(1);
                acc  <= fin ? '0 : acc_n;
                nacc <= fin ? '0 : nacc + AW'(1);
            end
            if (take && fin) begin
                word_q  <= acc_n;
                valid_q <= 1'b1;
                last_q  <= last_bit;
            end else if (accept) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end
    assign bus.rdReg      = state == LOAD;
    assign bus.op         = bus.rdReg ? {13'b0, sel_q} : 16'b0;
    assign bus.rdBit      = take;
    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
    assign bus.word_last  = last_q;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DRAIN && accept;
endmodule

// File: tb/tb_gps_ser_reader.sv
// tb_gps_ser_reader: scoreboard bench for gps_ser_reader with a behavioural GPS serial source
module tb_gps_ser_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    gps_ser_if bus ();
    gps_ser_reader dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // GPS source: bit stream left-aligned in sr, pointer restarts on rdReg, advances on rdBit
    logic [254:0] sr = '0;
    int idx = 0, n_rdreg = 0, n_rdbit = 0, n_done = 0;
    logic [15:0] exp_op = '0;
    assign bus.ser = (idx >= 0 && idx < 255) ? sr[254-idx] : 1'b0;
    always @(posedge clk) begin
        if (bus.rdReg) idx <= 0;
        else if (bus.rdBit) idx <= idx + 1;
        n_rdreg <= n_rdreg + int'(bus.rdReg);
        n_rdbit <= n_rdbit + int'(bus.rdBit);
        n_done  <= n_done + int'(bus.done);
    end
    typedef struct {logic [15:0] w; logic l;} item_t;
    item_t q[$];
    item_t it;
    logic [15:0] prev_w;
    logic prev_l, prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) prev_stall = 1'b0;
        else begin
            if (bus.rdReg) check("op", bus.op, exp_op);
            if (prev_stall) begin
                check("hold_word", bus.word, prev_w);
                check("hold_last", bus.word_last, prev_l);
                check("hold_valid", bus.word_valid, 1);
            end
            if (bus.word_valid && bus.word_ready) begin
                if (q.size() == 0) check("sb_empty", 1, 0);
                else begin
                    it = q.pop_front();
                    check("word", bus.word, it.w);
                    check("last", bus.word_last, it.l);
                    check("done", bus.done, it.l);
                end
            end else if (bus.done) check("done_stray", bus.done, 0);
            prev_stall = bus.word_valid && !bus.word_ready;
            prev_w = bus.word;
            prev_l = bus.word_last;
        end
    end
    task automatic load(input logic [2:0] s, input int n, input logic [254:0] v);
        logic [15:0] w = '0;
        int k = 0;
        sr = v << (255 - n);
        exp_op = {13'b0, s};
        for (int i = 0; i < n; i++) begin
            w = {w[14:0], sr[254-i]};
            k++;
            if (k == 16 || i == n - 1) begin
                q.push_back('{w, i == n - 1});
                w = '0;
                k = 0;
            end
        end
        bus.sel = s;
        bus.nbits = 8'(n);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic wait_done(input string tag, input int budget);
        int d0 = n_done;
        int t = 0;
        while (n_done == d0 && t < budget) begin
            @(posedge clk);
            #1 t++;
        end
        check(tag, n_done != d0, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_sb"}, q.size(), 0);
    endtask
    task automatic xfer(input string tag, input logic [2:0] s, input int n, input logic [254:0] v);
        int r0 = n_rdbit;
        int g0 = n_rdreg;
        load(s, n, v);
        wait_done(tag, 3 * n + 20);
        check({tag, "_rdbits"}, n_rdbit - r0, n);
        check({tag, "_rdregs"}, n_rdreg - g0, 1);
    endtask
    function automatic logic [63:0] outs();
        return {26'b0, bus.op, bus.rdReg, bus.rdBit, bus.word, bus.word_valid,
                bus.word_last, bus.busy, bus.done};
    endfunction
    initial begin
        int r0, g0, t;
        logic [254:0] rv;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sel = '0;
        bus.nbits = '0;
        bus.word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_outs", outs(), 0);
        rst = 1'b0;
        xfer("t16", 3'b100, 16, 255'h A5C3);
        xfer("t20", 3'b010, 20, 255'h 12345);
        bus.word_ready = 1'b0;
        r0 = n_rdbit;
        load(3'b001, 32, 255'h DEADBEEF);
        repeat (40) @(posedge clk);
        #1 check("stall_rdbit", bus.rdBit, 0);
        check("stall_word", bus.word, 16'hDEAD);
        check("stall_bits", n_rdbit - r0, 31);
        bus.word_ready = 1'b1;
        wait_done("t32", 100);
        check("t32_rdbits", n_rdbit - r0, 32);
        g0 = n_rdreg;
        bus.nbits = '0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) begin
            check("zero_busy", bus.busy, 0);
            check("zero_done", bus.done, 0);
            @(posedge clk);
            #1;
        end
        check("zero_rdreg", n_rdreg - g0, 0);
        r0 = n_rdbit;
        load(3'b010, 16, 255'h 3C5A);
        repeat (3) @(posedge clk);
        #1 bus.sel = 3'b001;
        bus.nbits = 8'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("busy_start", 100);
        check("busy_start_rdbits", n_rdbit - r0, 16);
        check("busy_start_rdregs", n_rdreg - g0, 1);
        r0 = n_rdbit;
        load(3'b001, 16, 255'h 0F0F);
        t = 0;
        while (!(bus.rdBit && n_rdbit - r0 == 4) && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        check("rst_reach5", t < 50, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_mid_outs", outs(), 0);
        rst = 1'b0;
        q.delete();
        check("rst_mid_bits", n_rdbit - r0, 5);
        g0 = n_rdreg;
        r0 = n_rdbit;
        repeat (5) @(posedge clk);
        #1 check("rst_quiet", (n_rdreg - g0) + (n_rdbit - r0), 0);
        xfer("after_rst", 3'b100, 16, 255'h 8001);
        for (int i = 0; i < 8; i++) rv = {rv[222:0], 32'($urandom)};
        xfer("t255", 3'b010, 255, rv);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
